// File: rtl/multiplier_n_bit_sequential_v.sv
// Shift-add WIDTH x WIDTH multiplier, unsigned or two's-complement per operation.
// Latency: start sample to o_done spans WIDTH+1 clock edges; back-to-back throughput is one product per WIDTH+1 cycles.
// Backpressure: i_start is ignored while o_busy is high; a start during the o_done cycle chains directly into a new operation.
module multiplier_n_bit_sequential_v #(
    parameter int WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_f
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [PW-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            neg_q,    neg_d;
    logic [PW-1:0]   acc_q,    acc_d;
    logic [PW-1:0]   f_q,      f_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             load;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        f_d      = f_q;
        load     = 1'b0;

        // Magnitudes stay WIDTH bits wide: the most negative operand maps to 2^(WIDTH-1).
        a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
        b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

        case (state_q)
            IDLE: begin
                load = i_start;
            end
            CALC: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    f_d     = neg_q ? -acc_d : acc_d;
                end
            end
            DONE: begin
                load = i_start;
                if (!i_start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d  = CALC;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            acc_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            f_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            f_q      <= f_d;
        end
    end

    assign o_busy = (state_q == CALC);
    assign o_done = (state_q == DONE);
    assign o_f    = f_q;

endmodule

// File: tb/tb_multiplier_n_bit_sequential_v.sv
// Directed bench for the sequential multiplier at WIDTH=4 and WIDTH=8 with a result scoreboard.
module tb_multiplier_n_bit_sequential_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start4, sgn4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] f4;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] f8;

    multiplier_n_bit_sequential_v #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_signed(sgn4),
        .i_a(a4), .i_b(b4), .o_busy(busy4), .o_done(done4), .o_f(f4)
    );

    multiplier_n_bit_sequential_v #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_signed(sgn8),
        .i_a(a8), .i_b(b8), .o_busy(busy8), .o_done(done8), .o_f(f8)
    );

    int total  = 0;
    int passed = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model4(input bit s, input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb;
        if (s) begin
            sa = {{4{a[3]}}, a};
            sb = {{4{b[3]}}, b};
            return 8'(sa * sb);
        end
        return {4'b0, a} * {4'b0, b};
    endfunction

    function automatic logic [15:0] model8(input bit s, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    // Counts cycles until o_done (bounded), then pops the scoreboard and checks o_f.
    task automatic wait_done4(input string tag, input bit drop, output int cyc, output int bc);
        logic [7:0] exp;
        cyc = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            bc += int'(busy4);
            if (drop && cyc == 1) start4 = 1'b0;
        end while (!done4 && cyc < 50);
        chk({tag, " done"}, 32'(done4), 32'd1);
        exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
        chk({tag, " f"}, 32'(f4), 32'(exp));
    endtask

    task automatic wait_done8(input string tag, output int cyc);
        logic [15:0] exp;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start8 = 1'b0;
        end while (!done8 && cyc < 50);
        chk({tag, " done"}, 32'(done8), 32'd1);
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        chk({tag, " f"}, 32'(f8), 32'(exp));
    endtask

    task automatic run4(input string tag, input bit s, input logic [3:0] a, input logic [3:0] b);
        int cyc, bc;
        logic [7:0] exp;
        exp = model4(s, a, b);
        @(negedge clk);
        start4 = 1'b1; sgn4 = s; a4 = a; b4 = b;
        q4.push_back(exp);
        wait_done4(tag, 1'b1, cyc, bc);
        chk({tag, " latency"}, 32'(cyc), 32'd5);
        chk({tag, " busy cycles"}, 32'(bc), 32'd4);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done4), 32'd0);
        chk({tag, " hold"}, 32'(f4), 32'(exp));
    endtask

    task automatic run8(input string tag, input bit s, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
        q8.push_back(model8(s, a, b));
        wait_done8(tag, cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd9);
    endtask

    initial begin
        int cyc, bc, extra_done, extra_busy;

        rst = 1'b1;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("rst busy4", 32'(busy4), 32'd0);
        chk("rst done4", 32'(done4), 32'd0);
        chk("rst f4",    32'(f4),    32'd0);
        chk("rst f8",    32'(f8),    32'd0);
        rst = 1'b0;

        // Unsigned
        run4("u 0*0",   1'b0, 4'd0,  4'd0);
        run4("u 15*15", 1'b0, 4'd15, 4'd15);
        chk("u 15*15 literal", 32'(f4), 32'h0E1);
        run4("u 15*0",  1'b0, 4'd15, 4'd0);
        run4("u 5*6",   1'b0, 4'd5,  4'd6);
        chk("u 5*6 literal", 32'(f4), 32'h01E);

        // Signed
        run4("s -8*-8", 1'b1, 4'h8, 4'h8);
        chk("s -8*-8 literal", 32'(f4), 32'h040);
        run4("s -3*5",  1'b1, 4'hD, 4'h5);
        run4("s 7*-8",  1'b1, 4'h7, 4'h8);
        chk("s 7*-8 literal", 32'(f4), 32'h0C8);
        run4("s -1*-1", 1'b1, 4'hF, 4'hF);
        run4("s 0*-5",  1'b1, 4'h0, 4'hB);

        // Starts and operand changes while busy must be ignored
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd3; b4 = 4'd4;
        q4.push_back(8'h0C);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
        @(negedge clk);
        start4 = 1'b0; sgn4 = 1'b0; a4 = 4'd5; b4 = 4'd2;
        wait_done4("busy prot", 1'b0, cyc, bc);
        chk("busy prot latency", 32'(cyc), 32'd2);
        extra_done = 0;
        extra_busy = 0;
        repeat (8) begin
            @(negedge clk);
            extra_done += int'(done4);
            extra_busy += int'(busy4);
        end
        chk("busy prot no extra done", 32'(extra_done), 32'd0);
        chk("busy prot no extra busy", 32'(extra_busy), 32'd0);

        // Back-to-back: start held, new operands presented in the DONE cycle
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd2; b4 = 4'd7;
        q4.push_back(8'h0E);
        wait_done4("b2b first", 1'b0, cyc, bc);
        chk("b2b first latency", 32'(cyc), 32'd5);
        chk("b2b first busy", 32'(bc), 32'd4);
        a4 = 4'd6; b4 = 4'd6;
        q4.push_back(8'h24);
        wait_done4("b2b second", 1'b1, cyc, bc);
        chk("b2b second latency", 32'(cyc), 32'd5);
        chk("b2b second busy", 32'(bc), 32'd4);

        // Reset in the second CALC cycle aborts the operation
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        chk("abort f",    32'(f4),    32'd0);
        rst = 1'b0;
        extra_done = 0;
        repeat (8) begin
            @(negedge clk);
            extra_done += int'(done4);
        end
        chk("abort no done", 32'(extra_done), 32'd0);
        chk("abort f holds", 32'(f4), 32'd0);
        run4("after abort 5*6", 1'b0, 4'd5, 4'd6);

        // WIDTH=8
        run8("w8 u 255*255", 1'b0, 8'hFF, 8'hFF);
        chk("w8 u literal", 32'(f8), 32'hFE01);
        run8("w8 s -128*-128", 1'b1, 8'h80, 8'h80);
        chk("w8 s sq literal", 32'(f8), 32'h4000);
        run8("w8 s -128*127", 1'b1, 8'h80, 8'h7F);
        chk("w8 s mixed literal", 32'(f8), 32'hC080);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multiplier_n_bit_sequential_v.md
Name: multiplier_n_bit_sequential_v

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the 4-bit combinational unsigned multiplier.
- Generalised to WIDTH-bit operands.
- Adds a per-operation signed/unsigned mode.
- Uses a start/done handshake and takes WIDTH+1 cycles per product.
- Targets datapaths where area matters more than single-cycle latency. One multiplier is shared by successive operations.

Parameters:
WIDTH, 4, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  request a multiply; sampled only when o_busy = 0.
i_signed  input  1  0 = unsigned operands, 1 = two's-complement signed operands; sampled with i_start.
i_a  input  WIDTH  multiplicand; sampled with i_start.
i_b  input  WIDTH  multiplier; sampled with i_start.
o_busy  output  1  high while an operation is in progress.
o_done  output  1  single-cycle pulse; o_f is valid from this cycle onward.
o_f  output  2*WIDTH  product; holds the last result until the next o_done.

Behaviour:
- Reset: i_clk and i_rst only; reset is synchronous and active-high. When i_rst is high at a rising edge:
  - state goes to IDLE;
  - o_busy = 0, o_done = 0, o_f = 0;
  - internal accumulator, operand registers and counter are cleared.
- Reset overrides all other inputs, including mid-operation. An aborted operation never asserts o_done, and o_f reads 0.
- States:
  - IDLE: o_busy = 0. If i_start = 1, latch the operands, go to CALC, counter = 0.
  - CALC: o_busy = 1. Exactly WIDTH cycles, one multiplier bit per cycle (LSB first). On the last cycle go to DONE.
  - DONE: o_busy = 0, o_done = 1 for this one cycle, o_f updated. If i_start = 1, accept a new operation directly (go to CALC). Otherwise go to IDLE.
- Latency:
  - If i_start is sampled at edge k, o_busy is high for edges k+1..k+WIDTH.
  - o_done is high after edge k+WIDTH+1, for exactly one cycle.
  - Back-to-back throughput is one product per WIDTH+1 cycles.
- Start handling: i_start while o_busy = 1 is ignored. Latched operands must not change mid-operation even if i_a, i_b or i_signed change.
- Unsigned mode: o_f = i_a * i_b, a full 2*WIDTH-bit result with no overflow possible. Example at WIDTH = 4: 15*15 = 225 = 0xE1.
- Signed mode:
  - Take the magnitudes of i_a and i_b, stored as WIDTH-bit unsigned values (so -2^(WIDTH-1) is representable).
  - Multiply the magnitudes unsigned.
  - Negate the 2*WIDTH-bit result if the operand signs differ.
  - The result always fits: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is less than 2^(2*WIDTH-1).
- Zero operand: the full WIDTH cycles still run (no early termination). o_f = 0 with no negative zero. A sign-differs negation of 0 yields 0.
- o_f changes only in the cycle o_done goes high, or on reset.

Test Plan:
- WIDTH=4, unsigned, with the bench waiting for o_done between pairs: (0,0), (15,15), (15,0), (5,6) -> o_f = 0x00, 0xE1, 0x00, 0x1E; o_done high exactly 5 cycles after each start, o_busy high for 4 cycles.
- WIDTH=4, signed: (-8,-8), (-3,5), (7,-8), (-1,-1), (0,-5) -> o_f = 0x40, 0xF1, 0xC8, 0x01, 0x00.
- Busy protection: start 3*4 unsigned, then pulse i_start with 9*9 and toggle i_a/i_b/i_signed during CALC -> single o_done, o_f = 0x0C; second request is not queued.
- Back-to-back: hold i_start high with 2*7, change to 6*6 in the DONE cycle -> o_f = 0x0E, then 0x24 five cycles later; o_busy low only during the DONE cycle.
- Reset mid-operation: start 15*15, assert i_rst in the 2nd CALC cycle -> o_busy = 0, o_done never pulses, o_f = 0; the next start of 5*6 gives 0x1E normally.
- WIDTH=8: unsigned 255*255 -> 0xFE01; signed -128*-128 -> 0x4000; signed -128*127 -> 0xC080; o_done 9 cycles after start.
